// File: rtl/div_loop_if.sv
// div_loop_if: request/result bundle for the div_loop sequential divider.
//   master: drives start, dividend, divisor; observes status and results
//   slave : the divider side
//   start       - one-cycle request
//   dividend    - unsigned numerator   (WIDTH_N)
//   divisor     - unsigned denominator (WIDTH_D)
//   busy        - iteration in progress
//   ready       - results valid
//   div_by_zero - captured divisor was zero (valid with ready)
//   quotient    - result (WIDTH_N)
//   remainder   - result (WIDTH_D)
interface div_loop_if #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
);
  logic               start;
  logic [WIDTH_N-1:0] dividend;
  logic [WIDTH_D-1:0] divisor;
  logic               busy;
  logic               ready;
  logic               div_by_zero;
  logic [WIDTH_N-1:0] quotient;
  logic [WIDTH_D-1:0] remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, ready, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, ready, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/div_loop.sv
// div_loop: sequential unsigned restoring divider, one quotient bit per clock.
// A start in IDLE or DONE captures the operands; after WIDTH_N iterations the
// quotient and remainder are presented with ready held high until the next
// accepted start or reset.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high, overrides everything
//   bus   - div_loop_if.slave (start/operands in, busy/ready/results out)
//
// state | meaning
// IDLE  | waiting for start; also the one-cycle settle after a zero divisor
// CALC  | shift-subtract iterations, busy=1
// DONE  | results valid, ready=1; start accepted again here
module div_loop #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
) (
  input logic       clk,
  input logic       reset,
  div_loop_if.slave bus
);

  localparam int CW = $clog2(WIDTH_N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH_N-1:0] q_reg;
  logic [WIDTH_D-1:0] d_reg;
  logic [WIDTH_D-1:0] r_reg;
  logic [CW-1:0]      cnt;
  logic               zero_pend;
  logic [WIDTH_N-1:0] quot_q;
  logic [WIDTH_D-1:0] rem_q;
  logic               dbz_q;

  logic               accept;
  logic               last_iter;
  logic [WIDTH_D:0]   t_val;
  logic               t_ge;
  logic [WIDTH_D-1:0] r_next;
  logic [WIDTH_N-1:0] q_next;

  always_comb begin
    state_d   = state_q;
    accept    = bus.start && ((state_q == IDLE && !zero_pend) || state_q == DONE);
    last_iter = (cnt == CW'(1));
    t_val     = {r_reg, q_reg[WIDTH_N-1]};
    t_ge      = (t_val >= {1'b0, d_reg});
    // When T >= D the true difference is < D, so a WIDTH_D-bit subtract is exact.
    r_next    = t_ge ? (t_val[WIDTH_D-1:0] - d_reg) : t_val[WIDTH_D-1:0];
    q_next    = {q_reg[WIDTH_N-2:0], t_ge};

    case (state_q)
      IDLE: begin
        if (zero_pend)
          state_d = DONE;
        else if (accept)
          state_d = (bus.divisor == '0) ? IDLE : CALC;
      end
      CALC: begin
        if (last_iter)
          state_d = DONE;
      end
      DONE: begin
        // A zero divisor parks in IDLE for one cycle so ready drops between
        // results exactly as it does for a normal request.
        if (accept)
          state_d = (bus.divisor == '0) ? IDLE : CALC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      zero_pend <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else if (accept) begin
      q_reg     <= bus.dividend;
      d_reg     <= bus.divisor;
      r_reg     <= '0;
      cnt       <= CW'(WIDTH_N);
      zero_pend <= (bus.divisor == '0);
      dbz_q     <= (bus.divisor == '0);
    end else if (state_q == CALC) begin
      q_reg <= q_next;
      r_reg <= r_next;
      cnt   <= cnt - CW'(1);
      if (last_iter) begin
        quot_q <= q_next;
        rem_q  <= r_next;
      end
    end else if (state_q == IDLE && zero_pend) begin
      quot_q    <= '1;
      rem_q     <= q_reg[WIDTH_D-1:0];
      zero_pend <= 1'b0;
    end
  end

  assign bus.busy        = (state_q == CALC);
  assign bus.ready       = (state_q == DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;

endmodule
